pwm_measure: RTL and testbench

- Receive-side counterpart of the breathing-LED PWM generator.
- Samples a PWM waveform, e.g. the generator's led output looped back or a pin.
- Measures period and high time in sys_clk cycles, and reports whether duty is rising or falling between consecutive periods.
- Used as a self-check / monitor block beside breath_led and as a generic PWM input decoder.

---
 rtl/pwm_measure.sv | 98 +++++++++
 tb/tb_pwm_measure.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pwm_measure.sv
// pwm_measure: measures period and high time of a PWM input in sys_clk cycles.
// Define PWM_MEAS_GLITCH_FILTER_EN to ignore 1-2 cycle input pulses (edge latency 3 -> 5 cycles).
module pwm_measure #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(60000)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] duty_cycle,
    output logic             meas_valid,
    output logic             inc_dec_flag,
    output logic             locked,
    output logic             meas_err
);
    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
    state_t           state;
    logic             s1, s2, dly, rise, fall;
    logic [CNT_W-1:0] run_cnt, high_hold;
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    logic s3, lvl, agree;
    // A new level is taken only when three consecutive synchronized samples agree.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) {s1, s2, s3, dly, lvl} <= '0;
        else begin
            {s1, s2, s3, dly} <= {pwm_in, s1, s2, s3};
            lvl <= agree ? s2 : lvl;
        end
    always_comb begin
        agree = (s2 == s3) && (s3 == dly);
        rise  = agree & s2 & ~lvl;
        fall  = agree & ~s2 & lvl;
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) {s1, s2, dly} <= '0;
        else {s1, s2, dly} <= {pwm_in, s1, s2};
    always_comb begin
        rise = s2 & ~dly;
        fall = ~s2 & dly;
    end
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state        <= IDLE;
            run_cnt      <= '0;
            high_hold    <= '0;
            period_cnt   <= '0;
            duty_cycle   <= '0;
            meas_valid   <= 1'b0;
            inc_dec_flag <= 1'b0;
            locked       <= 1'b0;
            meas_err     <= 1'b0;
        end else if (clr) begin
            state        <= IDLE;
            run_cnt      <= '0;
            high_hold    <= '0;
            period_cnt   <= '0;
            duty_cycle   <= '0;
            meas_valid   <= 1'b0;
            inc_dec_flag <= 1'b0;
            locked       <= 1'b0;
            meas_err     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            run_cnt    <= rise ? CNT_W'(1) :
                          (state != IDLE && run_cnt != TIMEOUT) ? run_cnt + CNT_W'(1) : run_cnt;
            case (state)
                IDLE: if (rise) state <= MEAS_HIGH;
                MEAS_HIGH:
                    if (run_cnt == TIMEOUT) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        meas_err <= 1'b1;
                    end else if (fall) begin
                        high_hold <= run_cnt;
                        state     <= MEAS_LOW;
                    end
                MEAS_LOW:
                    if (run_cnt == TIMEOUT) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        meas_err <= 1'b1;
                    end else if (rise) begin
                        // Trend is only meaningful against a measurement from the same lock.
                        if (locked && high_hold != duty_cycle) inc_dec_flag <= high_hold < duty_cycle;
                        period_cnt <= run_cnt;
                        duty_cycle <= high_hold;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                        state      <= MEAS_HIGH;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_pwm_measure.sv
// tb_pwm_measure: directed PWM waveforms against an event-level model of rise/fall timing.
module tb_pwm_measure;
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    localparam int LAT = 5, FMIN = 3;
`else
    localparam int LAT = 3, FMIN = 1;
`endif
    localparam int TMO = 200;

    logic        sys_clk = 0, sys_rst_n = 0, pwm_in = 0, clr = 0;
    logic [15:0] period_cnt, duty_cycle;
    logic        meas_valid, inc_dec_flag, locked, meas_err;
    int          cyc = 0, checks = 0, errors = 0, n_valid = 0;
    bit          chk_en = 0, hit;

    typedef struct {int c; bit clr; logic [15:0] p; logic [15:0] d; logic f;} ev_t;
    ev_t         exp_q[$];
    ev_t         ev;
    logic [15:0] e_p = 0, e_d = 0;
    logic        e_f = 0;
    bit          m_level, m_armed, m_locked, m_flag;
    int          m_rise, m_fall, m_duty;

    pwm_measure #(.CNT_W(16), .TIMEOUT(16'd200)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_in), .clr(clr),
        .period_cnt(period_cnt), .duty_cycle(duty_cycle), .meas_valid(meas_valid),
        .inc_dec_flag(inc_dec_flag), .locked(locked), .meas_err(meas_err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a level change at input cycle t (runs shorter than FMIN ignored) is seen LAT cycles later.
    task automatic model_seg(input bit lvl, input int len, input int t);
        int h;
        if (len < FMIN || lvl == m_level) return;
        m_level = lvl;
        if (!lvl) m_fall = t;
        else begin
            if (m_armed && t - m_rise < TMO) begin
                h = m_fall - m_rise;
                if (m_locked && h != m_duty) m_flag = h < m_duty;
                m_locked = 1;
                m_duty = h;
                exp_q.push_back('{t + LAT, 1'b0, 16'(t - m_rise), 16'(h), m_flag});
            end else m_locked = 0;
            m_armed = 1;
            m_rise = t;
        end
    endtask

    task automatic seg(input bit lvl, input int len);
        model_seg(lvl, len, cyc);
        pwm_in = lvl;
        repeat (len) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) if (chk_en) begin
        hit = 0;
        while (exp_q.size() != 0 && exp_q[0].c < cyc) begin
            check("missed_event", exp_q[0].c, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
            ev = exp_q.pop_front();
            e_p = ev.p;
            e_d = ev.d;
            e_f = ev.f;
            hit = !ev.clr;
        end
        n_valid += int'(meas_valid);
        check("meas_valid", meas_valid, hit);
        check("period_cnt", period_cnt, e_p);
        check("duty_cycle", duty_cycle, e_d);
        check("inc_dec_flag", inc_dec_flag, e_f);
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1;
        chk_en = 1;
        check("rst_period", period_cnt, 0);
        check("rst_locked", locked, 0);
        check("rst_err", meas_err, 0);
        seg(0, 100);
        check("idle_valid_cnt", n_valid, 0);
        check("idle_locked", locked, 0);
        for (int i = 0; i < 4; i++) begin
            seg(1, 3);
            seg(0, 5);
        end
        check("p8_valid_cnt", n_valid, 3);
        check("p8_period", period_cnt, 8);
        check("p8_duty", duty_cycle, 3);
        check("p8_locked", locked, 1);
        check("p8_flag", inc_dec_flag, 0);
        seg(1, 20); seg(0, 80); seg(1, 30); seg(0, 70); seg(1, 25); seg(0, 75); seg(1, 5);
        check("p100_period", period_cnt, 100);
        check("p100_duty", duty_cycle, 25);
        check("p100_flag", inc_dec_flag, 1);
        seg(0, 45); seg(1, 10); seg(0, 40); seg(1, 250);
        check("tmo_locked", locked, 0);
        check("tmo_err", meas_err, 1);
        check("tmo_period", period_cnt, 50);
        check("tmo_duty", duty_cycle, 10);
        seg(0, 20); seg(1, 20); seg(0, 30); seg(1, 20); seg(0, 30); seg(1, 5);
        check("relock_locked", locked, 1);
        check("relock_err", meas_err, 1);
        check("relock_duty", duty_cycle, 20);
        seg(0, 30);
        // clr lands on the same edge the rise is acted on
        exp_q.push_back('{cyc + LAT, 1'b1, 16'd0, 16'd0, 1'b0});
        m_level = 1; m_armed = 0; m_locked = 0; m_flag = 0; m_duty = 0;
        pwm_in = 1;
        repeat (LAT - 1) @(posedge sys_clk);
        #1;
        clr = 1;
        @(posedge sys_clk);
        #1;
        clr = 0;
        check("clr_locked", locked, 0);
        check("clr_err", meas_err, 0);
        check("clr_period", period_cnt, 0);
        check("clr_valid", meas_valid, 0);
        seg(1, 7); seg(0, 30); seg(1, 10); seg(0, 30); seg(1, 10);
        check("clr_relock_period", period_cnt, 40);
        check("clr_relock_locked", locked, 1);
        for (int i = 0; i < 2; i++) begin
            seg(0, 30); seg(1, 4); seg(0, 1); seg(1, 5);
        end
        seg(0, 30); seg(1, 10);
`ifdef PWM_MEAS_GLITCH_FILTER_EN
        check("glitch_period", period_cnt, 40);
        check("glitch_duty", duty_cycle, 10);
`else
        check("glitch_period", period_cnt, 35);
        check("glitch_duty", duty_cycle, 5);
`endif
        check("glitch_flag", inc_dec_flag, 0);
        seg(0, 20);
        check("pending_events", exp_q.size(), 0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
